// File: rtl/key_pkg.sv
// key_pkg
//   Shared definitions for the push-button debouncer.
//   - key_fsm_e    : filter FSM states (fixed 2-bit encoding)
//   - CNT_MAX_20MS : default stable-time terminal count, 20 ms at 50 MHz
//   - CNT_W_20MS   : counter width that holds CNT_MAX_20MS
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P_FILT = 2'd1,
    DOWN   = 2'd2,
    R_FILT = 2'd3
  } key_fsm_e;

  localparam int CNT_MAX_20MS = 999_999;
  localparam int CNT_W_20MS   = 20;

endpackage

// File: rtl/key_filter_if.sv
// key_filter_if
//   Bundles the button pin and the debounced outputs of key_filter.
//   - key_in      : raw button pin, asynchronous, 0 = pressed
//   - key_state   : debounced level, 1 = pressed
//   - key_flag    : one-cycle pulse on a debounced press
//   - key_release : one-cycle pulse on a debounced release
//   The master side drives the pin and consumes the outputs; the slave side
//   is the filter itself.
interface key_filter_if;

  logic key_in;
  logic key_state;
  logic key_flag;
  logic key_release;

  modport master (
    output key_in,
    input  key_state,
    input  key_flag,
    input  key_release
  );

  modport slave (
    input  key_in,
    output key_state,
    output key_flag,
    output key_release
  );

endinterface

// File: rtl/key_sync.sv
// key_sync
//   SYNC_STG-deep synchronizer that brings the asynchronous button pin into
//   the clk domain. Every stage resets to 1 so that a reset looks like a
//   released key.
//   - clk   : sampling clock, rising edge
//   - rst_n : asynchronous active-low reset
//   - d     : asynchronous input
//   - q     : synchronized output (last stage)
module key_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STG-1:0] sync_q;
  logic [SYNC_STG-1:0] sync_d;

  // New sample enters at bit 0 and moves one stage per clock.
  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STG-1];

endmodule

// File: rtl/key_filter.sv
// key_filter
//   Debounces one active-low push button. The pin is synchronized, then a
//   four-state FSM demands CNT_MAX+1 consecutive stable samples inside a
//   filter state before accepting a press or a release.
//   - sys_clk   : system clock, rising edge
//   - sys_rst_n : asynchronous active-low reset
//   - kif       : slave side of key_filter_if (key_in in; key_state,
//                 key_flag, key_release out, all registered)
module key_filter
  import key_pkg::*;
#(
  parameter int CNT_MAX  = CNT_MAX_20MS,
  parameter int CNT_W    = CNT_W_20MS,
  parameter int SYNC_STG = 2
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  key_filter_if.slave  kif
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  logic             key_s;
  key_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_state_q, key_state_d;
  logic             key_flag_q, key_flag_d;
  logic             key_release_q, key_release_d;

  key_sync #(
    .SYNC_STG (SYNC_STG)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (kif.key_in),
    .q     (key_s)
  );

  // Next-state logic. The counter is zero whenever a state is entered, so
  // only the filter states ever see a non-zero count, and it is cleared
  // before it can pass CNT_TOP. Strobes are raised on the transition into
  // the settled state, together with the new key_state level.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    key_state_d   = key_state_q;
    key_flag_d    = 1'b0;
    key_release_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = P_FILT;
        end
      end
      P_FILT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_TOP) begin
          state_d     = DOWN;
          key_flag_d  = 1'b1;
          key_state_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (key_s) begin
          state_d = R_FILT;
        end
      end
      R_FILT: begin
        if (!key_s) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_TOP) begin
          state_d       = IDLE;
          key_release_d = 1'b1;
          key_state_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers. A reset in any state lands in IDLE
  // with the outputs low, so an interrupted press never produces a release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_state_q   <= 1'b0;
      key_flag_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_state_q   <= key_state_d;
      key_flag_q    <= key_flag_d;
      key_release_q <= key_release_d;
    end
  end

  assign kif.key_state   = key_state_q;
  assign kif.key_flag    = key_flag_q;
  assign kif.key_release = key_release_q;

endmodule
